// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the 5-stage pipeline. It takes the EX/MEM register outputs
// directly, performs the data-memory / peripheral access and registers
// everything the WB stage needs into the MEM/WB pipeline register.
//
// Address map (word access only, addr[1:0] ignored):
//   0 .. RAM_WORDS*4-1   data RAM (contents not reset)
//   PERI_BASE + 0x00     TH   timer reload value, R/W
//   PERI_BASE + 0x04     TL   timer counter, R/W
//   PERI_BASE + 0x08     TCON bit0 enable, bit1 irq enable, bit2 status
//   PERI_BASE + 0x0C     LED[7:0], R/W
//   PERI_BASE + 0x10     switch[7:0], read-only, zero-extended
//   anything else        reads 0, writes ignored
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   instructionin/out          instruction, passed to MEM/WB
//   PCplusin/out               PC+4, passed to MEM/WB
//   ALUresultin/out            effective address / ALU result
//   DatabusBin                 store data
//   RegDstin/out, RegWrin/out  WB control, passed to MEM/WB
//   MemtoRegin/out             WB source select, passed to MEM/WB
//   MemWrin, MemRdin           memory write / read strobes
//   switch                     board switches
//   ReadDataout                registered load data (0 when MemRdin=0)
//   led                        LED register
//   irq                        timer interrupt request (registered level)
//
// Handshake: there is none. Every posedge accepts one EX/MEM word and
// produces one MEM/WB word; no stall, no flush, no back-pressure.
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int          RAM_WORDS = 256,
  parameter logic [31:0] PERI_BASE = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instructionin,
  input  logic [31:0] PCplusin,
  input  logic [31:0] ALUresultin,
  input  logic [31:0] DatabusBin,
  input  logic [1:0]  RegDstin,
  input  logic        RegWrin,
  input  logic        MemWrin,
  input  logic        MemRdin,
  input  logic [1:0]  MemtoRegin,
  input  logic [7:0]  switch,
  output logic [31:0] instructionout,
  output logic [31:0] PCplusout,
  output logic [31:0] ALUresultout,
  output logic [1:0]  RegDstout,
  output logic        RegWrout,
  output logic [1:0]  MemtoRegout,
  output logic [31:0] ReadDataout,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;
  // Peripheral decode is done on word addresses so addr[1:0] drops out.
  localparam logic [29:0] PB_W      = PERI_BASE[31:2];
  localparam logic [29:0] TH_W      = PB_W;
  localparam logic [29:0] TL_W      = PB_W + 30'd1;
  localparam logic [29:0] TCON_W    = PB_W + 30'd2;
  localparam logic [29:0] LED_W     = PB_W + 30'd3;
  localparam logic [29:0] SW_W      = PB_W + 30'd4;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   addr;
  logic [29:0]   word_addr;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          sel_th;
  logic          sel_tl;
  logic          sel_tcon;
  logic          sel_led;
  logic          sel_sw;

  assign addr      = ALUresultin;
  assign word_addr = addr[31:2];
  // Zero-extend so the compare is correct even when RAM_BYTES would be 2^32.
  assign ram_hit   = ({1'b0, addr} < RAM_BYTES);
  assign ram_idx   = addr[AW+1:2];

  // RAM takes priority should a parameter choice ever overlap the windows.
  assign sel_th   = ~ram_hit & (word_addr == TH_W);
  assign sel_tl   = ~ram_hit & (word_addr == TL_W);
  assign sel_tcon = ~ram_hit & (word_addr == TCON_W);
  assign sel_led  = ~ram_hit & (word_addr == LED_W);
  assign sel_sw   = ~ram_hit & (word_addr == SW_W);

  logic wr_ram;
  logic wr_th;
  logic wr_tl;
  logic wr_tcon;
  logic wr_led;

  assign wr_ram  = MemWrin & ram_hit;
  assign wr_th   = MemWrin & sel_th;
  assign wr_tl   = MemWrin & sel_tl;
  assign wr_tcon = MemWrin & sel_tcon;
  assign wr_led  = MemWrin & sel_led;

  // ---------------------------------------------------------------------------
  // Data RAM: synchronous write, combinational read, never reset.
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= DatabusBin;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer and LED registers
  // ---------------------------------------------------------------------------
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] tl_next;
  logic [2:0]  tcon_next;
  logic        ovf;
  logic        status_set;

  // Overflow is the enabled cycle in which TL sits at all-ones.
  assign ovf        = tcon[0] & (tl == 32'hFFFFFFFF);
  // A CPU write to TL or TCON in the overflow cycle wins and the status set
  // is dropped.
  assign status_set = ovf & tcon[1] & ~wr_tl & ~wr_tcon;

  always_comb begin
    tl_next   = tl;
    tcon_next = tcon;
    if (tcon[0]) begin
      tl_next = ovf ? th : (tl + 32'd1);
    end
    if (status_set) begin
      tcon_next[2] = 1'b1;
    end
    if (wr_tl) begin
      tl_next = DatabusBin;
    end
    if (wr_tcon) begin
      // Status bit is only cleared by software writing 0 to it.
      tcon_next = DatabusBin[2:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      irq  <= 1'b0;
    end else begin
      tl   <= tl_next;
      tcon <= tcon_next;
      if (wr_th) begin
        th <= DatabusBin;
      end
      if (wr_led) begin
        led <= DatabusBin[7:0];
      end
      // Registered from the current TCON, so irq lags TCON by one cycle.
      irq <= tcon[1] & tcon[2];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux. Sampled before the write lands, so a simultaneous read and
  // write returns the old value.
  // ---------------------------------------------------------------------------
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram[ram_idx];
    end else if (sel_th) begin
      rdata = th;
    end else if (sel_tl) begin
      rdata = tl;
    end else if (sel_tcon) begin
      rdata = {29'd0, tcon};
    end else if (sel_led) begin
      rdata = {24'd0, led};
    end else if (sel_sw) begin
      rdata = {24'd0, switch};
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instructionout <= '0;
      PCplusout      <= '0;
      ALUresultout   <= '0;
      RegDstout      <= '0;
      RegWrout       <= 1'b0;
      MemtoRegout    <= '0;
      ReadDataout    <= '0;
    end else begin
      instructionout <= instructionin;
      PCplusout      <= PCplusin;
      ALUresultout   <= ALUresultin;
      RegDstout      <= RegDstin;
      RegWrout       <= RegWrin;
      MemtoRegout    <= MemtoRegin;
      ReadDataout    <= MemRdin ? rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Bench for mem_access_stage: a vector table for RAM / peripheral accesses,
// hand-written sequences for the timer, pass-through and asynchronous reset,
// and a random RAM phase checked against a small word-array model.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam logic [31:0] PB = 32'h40000000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic [31:0] instructionin;
  logic [31:0] PCplusin;
  logic [31:0] ALUresultin;
  logic [31:0] DatabusBin;
  logic [1:0]  RegDstin;
  logic        RegWrin;
  logic        MemWrin;
  logic        MemRdin;
  logic [1:0]  MemtoRegin;
  logic [7:0]  switch;
  logic [31:0] instructionout;
  logic [31:0] PCplusout;
  logic [31:0] ALUresultout;
  logic [1:0]  RegDstout;
  logic        RegWrout;
  logic [1:0]  MemtoRegout;
  logic [31:0] ReadDataout;
  logic [7:0]  led;
  logic        irq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage #(.RAM_WORDS(256), .PERI_BASE(PB)) dut (
    .clk            (clk),
    .reset          (reset),
    .instructionin  (instructionin),
    .PCplusin       (PCplusin),
    .ALUresultin    (ALUresultin),
    .DatabusBin     (DatabusBin),
    .RegDstin       (RegDstin),
    .RegWrin        (RegWrin),
    .MemWrin        (MemWrin),
    .MemRdin        (MemRdin),
    .MemtoRegin     (MemtoRegin),
    .switch         (switch),
    .instructionout (instructionout),
    .PCplusout      (PCplusout),
    .ALUresultout   (ALUresultout),
    .RegDstout      (RegDstout),
    .RegWrout       (RegWrout),
    .MemtoRegout    (MemtoRegout),
    .ReadDataout    (ReadDataout),
    .led            (led),
    .irq            (irq)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram_model [256];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: presents one EX/MEM word for one cycle. When chk is set the
  // expected load result is queued and compared once the word has passed the
  // MEM/WB register (#1 after the capturing edge).
  // ---------------------------------------------------------------------------
  task automatic drive(input string name, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic chk, input logic [31:0] req);
    logic [31:0] e;
    MemWrin     = wr;
    MemRdin     = rd;
    ALUresultin = a;
    DatabusBin  = d;
    if (chk) exp_q.push_back(req);
    @(posedge clk);
    #1;
    if (chk) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty actual=%h required=none", name, ReadDataout);
      end else begin
        e = exp_q.pop_front();
        check(name, ReadDataout, e);
      end
    end
    MemWrin     = 1'b0;
    MemRdin     = 1'b0;
    ALUresultin = '0;
    DatabusBin  = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive("idle", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string name, input logic wr, input logic rd,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic chk, input logic [31:0] e);
    vec_t v;
    v.name = name; v.wr = wr; v.rd = rd; v.addr = a; v.data = d;
    v.chk = chk; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          idx;

    reset         = 1'b1;
    instructionin = '0;
    PCplusin      = '0;
    ALUresultin   = '0;
    DatabusBin    = '0;
    RegDstin      = '0;
    RegWrin       = 1'b0;
    MemWrin       = 1'b0;
    MemRdin       = 1'b0;
    MemtoRegin    = '0;
    switch        = 8'h3C;

    vecs.push_back(mk("sw_10",        1, 0, 32'h10,        32'hDEADBEEF, 0, 0));
    vecs.push_back(mk("lw_10",        0, 1, 32'h10,        0,            1, 32'hDEADBEEF));
    vecs.push_back(mk("lw_12",        0, 1, 32'h12,        0,            1, 32'hDEADBEEF));
    vecs.push_back(mk("lw_2000",      0, 1, 32'h2000,      0,            1, 32'h0));
    vecs.push_back(mk("sw_0",         1, 0, 32'h0,         32'h11111111, 0, 0));
    vecs.push_back(mk("sw_2000",      1, 0, 32'h2000,      32'h22222222, 0, 0));
    vecs.push_back(mk("lw_0_kept",    0, 1, 32'h0,         0,            1, 32'h11111111));
    vecs.push_back(mk("sw_3fc",       1, 0, 32'h3FC,       32'hCAFEF00D, 0, 0));
    vecs.push_back(mk("lw_3fc",       0, 1, 32'h3FC,       0,            1, 32'hCAFEF00D));
    vecs.push_back(mk("lw_400",       0, 1, 32'h400,       0,            1, 32'h0));
    vecs.push_back(mk("rdwr_old",     1, 1, 32'h10,        32'h12345678, 1, 32'hDEADBEEF));
    vecs.push_back(mk("lw_10_new",    0, 1, 32'h10,        0,            1, 32'h12345678));
    vecs.push_back(mk("no_rd_zero",   0, 0, 32'h10,        0,            1, 32'h0));
    vecs.push_back(mk("sw_led",       1, 0, PB + 32'hC,    32'h000000A5, 0, 0));
    vecs.push_back(mk("lw_led",       0, 1, PB + 32'hC,    0,            1, 32'hA5));
    vecs.push_back(mk("lw_switch",    0, 1, PB + 32'h10,   0,            1, 32'h3C));
    vecs.push_back(mk("sw_th",        1, 0, PB,            32'hFFFFFFFC, 0, 0));
    vecs.push_back(mk("lw_th",        0, 1, PB,            0,            1, 32'hFFFFFFFC));
    vecs.push_back(mk("lw_unmapped",  0, 1, PB + 32'h14,   0,            1, 32'h0));
    vecs.push_back(mk("sw_tcon_f8",   1, 0, PB + 32'h8,    32'hFFFFFFF8, 0, 0));
    vecs.push_back(mk("lw_tcon_hi0",  0, 1, PB + 32'h8,    0,            1, 32'h0));
    vecs.push_back(mk("sw_tl",        1, 0, PB + 32'h4,    32'hFFFFFFFE, 0, 0));
    vecs.push_back(mk("lw_tl_hold",   0, 1, PB + 32'h4,    0,            1, 32'hFFFFFFFE));

    // Reset and release with idle inputs.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    check("rst_readdata", ReadDataout, 32'h0);
    check("rst_instr",    instructionout, 32'h0);
    check("rst_pcplus",   PCplusout, 32'h0);
    check("rst_alu",      ALUresultout, 32'h0);
    check("rst_ctrl",     {26'd0, RegDstout, RegWrout, MemtoRegout}, 32'h0);
    check("rst_led",      {24'd0, led}, 32'h0);
    check("rst_irq",      {31'd0, irq}, 32'h0);

    foreach (vecs[i])
      drive(vecs[i].name, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
            vecs[i].chk, vecs[i].exp);
    check("led_port", {24'd0, led}, 32'hA5);

    // Timer: TH=FFFFFFFC, TL=FFFFFFFE, then enable with irq enable.
    drive("sw_tcon_3", 1, 0, PB + 32'h8, 32'h3, 0, 0);
    idle(1);                                           // TL -> FFFFFFFF
    drive("tl_allones", 0, 1, PB + 32'h4, 0, 1, 32'hFFFFFFFF);
    check("irq_lag", {31'd0, irq}, 32'h0);             // reload just happened
    drive("tl_reload", 0, 1, PB + 32'h4, 0, 1, 32'hFFFFFFFC);
    check("irq_set", {31'd0, irq}, 32'h1);
    drive("tcon_status", 0, 1, PB + 32'h8, 0, 1, 32'h7);
    drive("sw_tcon_clr", 1, 0, PB + 32'h8, 32'h3, 0, 0);
    idle(1);
    check("irq_clear", {31'd0, irq}, 32'h0);

    // Overflow cycle coincident with a TL write: write wins, no status.
    drive("sw_tcon_0", 1, 0, PB + 32'h8, 32'h0, 0, 0);
    drive("sw_tl_fe",  1, 0, PB + 32'h4, 32'hFFFFFFFE, 0, 0);
    drive("sw_tcon_3b", 1, 0, PB + 32'h8, 32'h3, 0, 0);
    idle(1);                                           // TL -> FFFFFFFF
    drive("sw_tl_5", 1, 0, PB + 32'h4, 32'h5, 0, 0);   // overflow cycle
    drive("tcon_nostat", 0, 1, PB + 32'h8, 0, 1, 32'h3);
    drive("tl_after_5", 0, 1, PB + 32'h4, 0, 1, 32'h6);
    idle(1);
    check("irq_nostat", {31'd0, irq}, 32'h0);

    // Pass-through of the MEM/WB register.
    instructionin = 32'h8C8A0010;
    PCplusin      = 32'h00400008;
    RegWrin       = 1'b1;
    RegDstin      = 2'd2;
    MemtoRegin    = 2'd2;
    drive("pass", 0, 0, 32'h00001234, 0, 0, 0);
    check("pass_instr", instructionout, 32'h8C8A0010);
    check("pass_pcplus", PCplusout, 32'h00400008);
    check("pass_alu", ALUresultout, 32'h00001234);
    check("pass_ctrl", {26'd0, RegDstout, RegWrout, MemtoRegout}, {26'd0, 2'd2, 1'b1, 2'd2});
    instructionin = '0;
    PCplusin      = '0;
    RegWrin       = 1'b0;
    RegDstin      = '0;
    MemtoRegin    = '0;

    // Random RAM traffic against a word-array model.
    for (int i = 0; i < 256; i++) ram_model[i] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      a = {22'd0, 8'(i + 64), 2'b00};
      d = $urandom;
      ram_model[i + 64] = d;
      drive("rnd_init", 1, 0, a, d, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(64, 79);
      a   = {22'd0, 8'(idx), 2'(($urandom_range(0, 3)))};
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        drive("rnd_sw", 1, 0, a, d, 0, 0);
        ram_model[idx] = d;
      end else begin
        drive("rnd_lw", 0, 1, a, 0, 1, ram_model[idx]);
      end
    end

    // Asynchronous reset while the timer has irq raised.
    drive("sw_tcon_0c", 1, 0, PB + 32'h8, 32'h0, 0, 0);
    drive("sw_th_0",    1, 0, PB,         32'h0, 0, 0);
    drive("sw_tl_ff",   1, 0, PB + 32'h4, 32'hFFFFFFFF, 0, 0);
    drive("sw_tcon_3c", 1, 0, PB + 32'h8, 32'h3, 0, 0);
    idle(2);
    check("irq_pre_rst", {31'd0, irq}, 32'h1);
    #3 reset = 1'b1;
    #1;
    check("async_irq", {31'd0, irq}, 32'h0);
    check("async_led", {24'd0, led}, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive("tl_after_rst",   0, 1, PB + 32'h4, 0, 1, 32'h0);
    drive("tcon_after_rst", 0, 1, PB + 32'h8, 0, 1, 32'h0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
